// File: rtl/conv_tile_ctrl.sv
// Tile-level sequencer for the convolution datapath: load -> compute -> store per tile,
// stepping oc/row/col/ic tile indices as an odometer (ic innermost) until the layer is done.
module conv_tile_ctrl #(
  parameter int OC_TILES  = 2,
  parameter int ROW_TILES = 2,
  parameter int COL_TILES = 2,
  parameter int IC_TILES  = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             load_start,
  input  logic             conv_load_done,
  output logic             conv_start,
  input  logic             conv_done,
  output logic             store_start,
  input  logic             store_done,
  output logic [CNT_W-1:0] oc_idx,
  output logic [CNT_W-1:0] row_idx,
  output logic [CNT_W-1:0] col_idx,
  output logic [CNT_W-1:0] ic_idx,
  output logic             acc_clear,
  output logic             busy,
  output logic             layer_done
);

  // state | meaning
  // IDLE  | waiting for start; indices hold the last layer's final tile
  // LOAD  | pulse load_start for the three loaders
  // LWAIT | wait for conv_load_done
  // COMP  | pulse conv_start
  // CWAIT | wait for conv_done
  // STORE | pulse store_start
  // SWAIT | wait for store_done
  // NEXT  | advance tile odometer or finish
  // DONE  | pulse layer_done
  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_LWAIT, S_COMP, S_CWAIT, S_STORE, S_SWAIT, S_NEXT, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] OC_MAX  = CNT_W'(OC_TILES - 1);
  localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(ROW_TILES - 1);
  localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(COL_TILES - 1);
  localparam logic [CNT_W-1:0] IC_MAX  = CNT_W'(IC_TILES - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] oc_q, oc_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] ic_q, ic_d;

  logic oc_last, row_last, col_last, ic_last;

  assign oc_last  = (oc_q == OC_MAX);
  assign row_last = (row_q == ROW_MAX);
  assign col_last = (col_q == COL_MAX);
  assign ic_last  = (ic_q == IC_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      oc_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      ic_q    <= '0;
    end else begin
      state_q <= state_d;
      oc_q    <= oc_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ic_q    <= ic_d;
    end
  end

  always_comb begin
    state_d = state_q;
    oc_d    = oc_q;
    row_d   = row_q;
    col_d   = col_q;
    ic_d    = ic_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          oc_d    = '0;
          row_d   = '0;
          col_d   = '0;
          ic_d    = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_LWAIT;
      S_LWAIT: if (conv_load_done) state_d = S_COMP;
      S_COMP:  state_d = S_CWAIT;
      S_CWAIT: if (conv_done) state_d = S_STORE;
      S_STORE: state_d = S_SWAIT;
      S_SWAIT: if (store_done) state_d = S_NEXT;
      S_NEXT: begin
        // Final tile leaves the indices at their maxima for observation until the next start.
        if (oc_last && row_last && col_last && ic_last) begin
          state_d = S_DONE;
        end else begin
          state_d = S_LOAD;
          if (!ic_last) begin
            ic_d = ic_q + ONE;
          end else begin
            ic_d = '0;
            if (!col_last) begin
              col_d = col_q + ONE;
            end else begin
              col_d = '0;
              if (!row_last) begin
                row_d = row_q + ONE;
              end else begin
                row_d = '0;
                oc_d  = oc_q + ONE;
              end
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign load_start  = (state_q == S_LOAD);
  assign conv_start  = (state_q == S_COMP);
  assign store_start = (state_q == S_STORE);
  assign layer_done  = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);

  assign oc_idx    = oc_q;
  assign row_idx   = row_q;
  assign col_idx   = col_q;
  assign ic_idx    = ic_q;
  assign acc_clear = (ic_q == '0);

endmodule

// File: tb/tb_conv_tile_ctrl.sv
// Directed bench for conv_tile_ctrl: a single-tile instance and an OC=2/ROW=2/COL=1/IC=2 instance.
module tb_conv_tile_ctrl;

  logic clk;
  logic rst;

  logic       s_start, s_cld, s_cd, s_sd;
  logic       s_ls, s_cs, s_ss, s_ac, s_busy, s_ld;
  logic [7:0] s_oc, s_row, s_col, s_ic;

  logic       m_start, m_cld, m_cd, m_sd;
  logic       m_ls, m_cs, m_ss, m_ac, m_busy, m_ld;
  logic [7:0] m_oc, m_row, m_col, m_ic;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ls_cnt = 0;
  int ld_cnt = 0;

  conv_tile_ctrl #(.OC_TILES(1), .ROW_TILES(1), .COL_TILES(1), .IC_TILES(1), .CNT_W(8)) u_one (
    .clk(clk), .rst(rst), .start(s_start),
    .load_start(s_ls), .conv_load_done(s_cld),
    .conv_start(s_cs), .conv_done(s_cd),
    .store_start(s_ss), .store_done(s_sd),
    .oc_idx(s_oc), .row_idx(s_row), .col_idx(s_col), .ic_idx(s_ic),
    .acc_clear(s_ac), .busy(s_busy), .layer_done(s_ld)
  );

  conv_tile_ctrl #(.OC_TILES(2), .ROW_TILES(2), .COL_TILES(1), .IC_TILES(2), .CNT_W(8)) u_main (
    .clk(clk), .rst(rst), .start(m_start),
    .load_start(m_ls), .conv_load_done(m_cld),
    .conv_start(m_cs), .conv_done(m_cd),
    .store_start(m_ss), .store_done(m_sd),
    .oc_idx(m_oc), .row_idx(m_row), .col_idx(m_col), .ic_idx(m_ic),
    .acc_clear(m_ac), .busy(m_busy), .layer_done(m_ld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_ls) ls_cnt <= ls_cnt + 1;
    if (m_ld) ld_cnt <= ld_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic msig(input int sel);
    case (sel)
      0:       return m_ls;
      1:       return m_cs;
      2:       return m_ss;
      default: return m_ld;
    endcase
  endfunction

  task automatic wait_pulse(input int sel, input string tag);
    int n = 0;
    while (msig(sel) !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check(tag, {31'd0, msig(sel)}, 32'd1);
  endtask

  // One tile on u_main: expects load_start now (or soon), responds after lat wait cycles, ends in NEXT.
  task automatic do_tile(input int e_oc, input int e_row, input int e_ic, input int lat,
                         output int t_load);
    wait_pulse(0, "tile_load_start");
    t_load = cyc;
    check("tile_idx", {m_oc, m_row, m_col, m_ic}, {8'(e_oc), 8'(e_row), 8'd0, 8'(e_ic)});
    check("tile_acc_clear", {31'd0, m_ac}, {31'd0, e_ic == 0});
    tick();
    repeat (lat) tick();
    m_cld = 1'b1; tick(); m_cld = 1'b0;
    check("tile_conv_start", {31'd0, m_cs}, 32'd1);
    tick();
    repeat (lat) tick();
    m_cd = 1'b1; tick(); m_cd = 1'b0;
    check("tile_store_start", {31'd0, m_ss}, 32'd1);
    tick();
    repeat (lat) tick();
    m_sd = 1'b1; tick(); m_sd = 1'b0;
    check("tile_next_busy", {29'd0, m_busy, m_ls, m_ld}, 32'd4);
  endtask

  initial begin
    int t_load;
    int t_prev;
    int ls_base;
    int ld_base;
    rst = 1'b1;
    s_start = 0; s_cld = 0; s_cd = 0; s_sd = 0;
    m_start = 0; m_cld = 0; m_cd = 0; m_sd = 0;
    tick();
    tick();

    // Reset state of both instances
    check("rst_main_outs", {26'd0, m_busy, m_ls, m_cs, m_ss, m_ld, m_ac}, 32'd1);
    check("rst_main_idx", {m_oc, m_row, m_col, m_ic}, 32'd0);
    check("rst_one_outs", {26'd0, s_busy, s_ls, s_cs, s_ss, s_ld, s_ac}, 32'd1);
    check("rst_one_idx", {s_oc, s_row, s_col, s_ic}, 32'd0);
    rst = 1'b0;
    tick();

    // Single tile: start at cycle 0, each done 3 cycles after its start pulse
    for (int c = 0; c <= 16; c++) begin
      check($sformatf("single_c%0d", c), {27'd0, s_busy, s_ld, s_ss, s_cs, s_ls},
            {27'd0, (c >= 1 && c <= 14), (c == 14), (c == 9), (c == 5), (c == 1)});
      s_start = (c == 0);
      s_cld   = (c == 4);
      s_cd    = (c == 8);
      s_sd    = (c == 12);
      tick();
    end
    s_start = 0; s_cld = 0; s_cd = 0; s_sd = 0;
    check("single_idx_after", {s_oc, s_row, s_col, s_ic, 7'd0, s_ac}, 40'd1);

    // Loop order with spurious pulses and start-while-busy on tile 0
    ls_base = ls_cnt;
    ld_base = ld_cnt;
    m_start = 1'b1; tick(); m_start = 1'b0;
    check("l0_load_start", {31'd0, m_ls}, 32'd1);
    check("l0_idx", {m_oc, m_row, m_col, m_ic}, 32'd0);
    m_cld = 1'b1; tick(); m_cld = 1'b0;
    m_cd = 1'b1; m_sd = 1'b1; tick(); m_cd = 1'b0; m_sd = 1'b0;
    check("lwait_ignore_a", {29'd0, m_busy, m_cs, m_ss}, 32'd4);
    tick();
    check("lwait_ignore_b", {29'd0, m_busy, m_cs, m_ss}, 32'd4);
    m_cld = 1'b1; tick(); m_cld = 1'b0;
    check("l0_conv_start", {31'd0, m_cs}, 32'd1);
    tick();
    m_start = 1'b1; tick(); m_start = 1'b0;
    check("cwait_start_ignored", {m_oc, m_row, m_col, m_ic}, 32'd0);
    m_cd = 1'b1; tick(); m_cd = 1'b0;
    check("l0_store_start", {31'd0, m_ss}, 32'd1);
    tick();
    m_start = 1'b1; tick(); m_start = 1'b0;
    check("swait_start_ignored", {m_oc, m_row, m_col, m_ic}, 32'd0);
    m_sd = 1'b1; tick(); m_sd = 1'b0;
    for (int t = 1; t < 8; t++) begin
      do_tile((t >> 2) & 1, (t >> 1) & 1, t & 1, 1 + (t % 3), t_load);
    end
    tick();
    check("loop_layer_done", {31'd0, m_ld}, 32'd1);
    check("loop_final_idx", {m_oc, m_row, m_col, m_ic}, 32'h01010001);
    tick();
    check("loop_busy_low", {31'd0, m_busy}, 32'd0);
    check("loop_load_count", 32'(ls_cnt - ls_base), 32'd8);
    check("loop_done_count", 32'(ld_cnt - ld_base), 32'd1);
    check("idle_idx_hold", {m_oc, m_row, m_col, m_ic}, 32'h01010001);

    // Reset during CWAIT of tile 3
    m_start = 1'b1; tick(); m_start = 1'b0;
    do_tile(0, 0, 0, 1, t_load);
    do_tile(0, 0, 1, 0, t_load);
    do_tile(0, 1, 0, 2, t_load);
    wait_pulse(0, "t3_load_start");
    check("t3_idx", {m_oc, m_row, m_col, m_ic}, 32'h00010001);
    tick();
    m_cld = 1'b1; tick(); m_cld = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check("rst_async_busy", {30'd0, m_busy, m_ac}, 32'd1);
    check("rst_async_idx", {m_oc, m_row, m_col, m_ic}, 32'd0);
    tick();
    rst = 1'b0;
    m_cd = 1'b1; tick(); m_cd = 1'b0;
    tick();
    check("post_rst_done_ignored", {29'd0, m_busy, m_ss, m_cs}, 32'd0);

    // Restart with zero-latency responders: 7-cycle tile period
    m_start = 1'b1; tick(); m_start = 1'b0;
    t_prev = 0;
    for (int t = 0; t < 8; t++) begin
      do_tile((t >> 2) & 1, (t >> 1) & 1, t & 1, 0, t_load);
      if (t > 0) check($sformatf("zl_period_%0d", t), 32'(t_load - t_prev), 32'd7);
      t_prev = t_load;
    end
    tick();
    check("zl_layer_done", {31'd0, m_ld}, 32'd1);
    tick();
    check("zl_busy_low", {31'd0, m_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
